// File: rtl/enemy_hp_drain_pkg.sv
// Shared battle types and defaults, also used by the HP-bar renderer.
package enemy_hp_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_REPORT,
    ST_DEAD
  } state_t;

  typedef logic [7:0] hp_t;
  typedef logic [7:0] dmg_t;

  localparam int HP_MAX_DEF    = 100;
  localparam int DRAIN_DIV_DEF = 4;

endpackage

// File: rtl/enemy_hp_drain_ticker.sv
// Drain pacing counter: fire every DIV enabled cycles.
// Built only when ENEMY_HP_DRAIN_ANIM_EN is defined.
`ifdef ENEMY_HP_DRAIN_ANIM_EN
module drain_ticker #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic fire
);

  logic [7:0] tick;

  assign fire = en & (tick == 8'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
    end else if (clr) begin
      tick <= '0;
    end else if (en) begin
      tick <= fire ? 8'd0 : tick + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/enemy_hp_drain.sv
// Applies attack damage to enemy HP; ENEMY_HP_DRAIN_ANIM_EN
// selects the one-point-per-tick drain over the single-step one.
module enemy_hp_drain
  import enemy_hp_drain_pkg::*;
#(
  parameter int HP_MAX    = HP_MAX_DEF,
  parameter int DRAIN_DIV = DRAIN_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       atk_pass,
  input  logic [7:0] atk_damage,
  input  logic       new_battle,
  output logic [7:0] enemy_hp,
  output logic       drain_busy,
  output logic       miss,
  output logic       turn_done,
  output logic       enemy_dead,
  output logic       hit_overrun
);

  localparam hp_t HP_INIT = hp_t'(HP_MAX);

  state_t state_q, state_d;
  hp_t    hp_q, hp_d;
  dmg_t   pend_q, pend_d;
  logic   pass_q;
  logic   miss_q, miss_d;
  logic   done_q, done_d;
  logic   ovr_q, ovr_d;
  logic   hit;

  assign hit = atk_pass & ~pass_q;

`ifdef ENEMY_HP_DRAIN_ANIM_EN
  logic fire;

  drain_ticker #(
    .DIV (DRAIN_DIV)
  ) u_ticker (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_DRAIN),
    .clr   ((state_q != ST_DRAIN) | new_battle),
    .fire  (fire)
  );
`else
  localparam int unused_drain_div = DRAIN_DIV;
`endif

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    miss_d  = 1'b0;
    done_d  = 1'b0;
    if (new_battle) begin
      state_d = ST_IDLE;
      hp_d    = HP_INIT;
      pend_d  = '0;
      ovr_d   = 1'b0;
    end else begin
      done_d = (state_q == ST_REPORT);
      unique case (state_q)
        ST_IDLE: begin
          if (hit && atk_damage != 8'd0) begin
            pend_d  = atk_damage;
            state_d = ST_DRAIN;
          end else if (hit) begin
            miss_d  = 1'b1;
            state_d = ST_REPORT;
          end
        end
        ST_DRAIN: begin
          if (hit) ovr_d = 1'b1;
`ifdef ENEMY_HP_DRAIN_ANIM_EN
          // Stop on whichever runs out first so HP never wraps.
          if (fire) begin
            hp_d   = hp_q - 8'd1;
            pend_d = pend_q - 8'd1;
            if (hp_q == 8'd1 || pend_q == 8'd1)
              state_d = ST_REPORT;
          end
`else
          hp_d    = (hp_q > pend_q) ? hp_q - pend_q : 8'd0;
          pend_d  = '0;
          state_d = ST_REPORT;
`endif
        end
        ST_REPORT: begin
          if (hit) ovr_d = 1'b1;
          state_d = (hp_q == 8'd0) ? ST_DEAD : ST_IDLE;
        end
        ST_DEAD: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hp_q    <= HP_INIT;
      pend_q  <= '0;
      pass_q  <= 1'b1;
      miss_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      pend_q  <= pend_d;
      pass_q  <= atk_pass;
      miss_q  <= miss_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign enemy_hp    = hp_q;
  assign drain_busy  = (state_q == ST_DRAIN);
  assign enemy_dead  = (state_q == ST_DEAD);
  assign miss        = miss_q;
  assign turn_done   = done_q;
  assign hit_overrun = ovr_q;

endmodule
